// File: rtl/spi_ram_pkg.sv
// Shared opcode definitions for the SPI command-decoded RAM.
// Opcode sits in the top OP_W bits of each received word.
package spi_ram_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_WADDR = 2'b00,
    OP_WDATA = 2'b01,
    OP_RADDR = 2'b10,
    OP_RDATA = 2'b11
  } op_e;

endpackage

// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave FSM and the RAM.
// master = SPI slave side, slave = RAM side.
interface spi_ram_burst_if #(
  parameter int DATA_W = 8
);
  import spi_ram_pkg::*;

  logic                   rx_valid;
  logic [DATA_W+OP_W-1:0] din;
  logic [DATA_W-1:0]      dout;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   ovf;

  modport master (
    output rx_valid, din, tx_ready,
    input  dout, tx_valid, ovf
  );

  modport slave (
    input  rx_valid, din, tx_ready,
    output dout, tx_valid, ovf
  );

endinterface

// File: rtl/spi_ram_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// Out-of-range writes are dropped and out-of-range reads return 0.
module spi_ram_mem #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = {1'b0, waddr_i} < DEPTH_L;
  assign rd_ok = {1'b0, raddr_i} < DEPTH_L;

  always_ff @(posedge clk) begin
    if (we_i && wr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= rd_ok ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command-decoded SPI RAM with registered tx handshake and overrun flag.
// Define SPI_RAM_AUTOINC_EN for burst address post-increment.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 1 << ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  spi_ram_burst_if.slave bus
);

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

  function automatic logic [ADDR_W-1:0] inc_wrap(
    input logic [ADDR_W-1:0] a
  );
    if (a == LAST) return '0;
    return a + 1'b1;
  endfunction

  op_e               op;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              ovf_q, ovf_d;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] rdata;

  assign op = op_e'(bus.din[DATA_W+OP_W-1:DATA_W]);

  spi_ram_mem #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (addr_wr_q),
    .wdata_i (bus.din[DATA_W-1:0]),
    .re_i    (mem_re),
    .raddr_i (addr_rd_q),
    .rdata_o (rdata)
  );

  always_comb begin
    addr_wr_d  = addr_wr_q;
    addr_rd_d  = addr_rd_q;
    rd_pend_d  = 1'b0;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    if (bus.rx_valid) begin
      unique case (1'b1)
        (op == OP_WADDR): begin
          addr_wr_d = bus.din[ADDR_W-1:0];
        end
        (op == OP_WDATA): begin
          mem_we = 1'b1;
          if (AUTOINC) addr_wr_d = inc_wrap(addr_wr_q);
        end
        (op == OP_RADDR): begin
          addr_rd_d = bus.din[ADDR_W-1:0];
        end
        (op == OP_RDATA): begin
          mem_re    = 1'b1;
          rd_pend_d = 1'b1;
          if (AUTOINC) addr_rd_d = inc_wrap(addr_rd_q);
        end
        default: ;
      endcase
    end

    // A landing read wins over the ack; landing on unconsumed data is an overrun.
    if (rd_pend_q) begin
      dout_d     = rdata;
      tx_valid_d = 1'b1;
      if (tx_valid_q && !bus.tx_ready) ovf_d = 1'b1;
    end else if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_wr_q  <= '0;
      addr_rd_q  <= '0;
      rd_pend_q  <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      addr_wr_q  <= addr_wr_d;
      addr_rd_q  <= addr_rd_d;
      rd_pend_q  <= rd_pend_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst with a cycle-level reference model.
// Honors SPI_RAM_AUTOINC_EN to pick the burst or legacy address test.
module tb_spi_ram_burst;
  import spi_ram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_ram_burst_if #(.DATA_W(DW)) bus();

  spi_ram_burst #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];

  // Reference model: memory array, two address pointers, and a list of
  // reads in flight tagged with the cycle at which each becomes visible.
  logic [7:0] mem_m [DEPTH];
  logic [7:0] aw_m, ar_m, exp_dout;
  logic       exp_tv, exp_ovf;
  int         cyc = 0;
  int         land_q[$];
  logic [7:0] data_q[$];

  always @(posedge clk) begin
    logic [1:0] mop;
    logic [7:0] pl;
    cyc = cyc + 1;
    if (rst) begin
      aw_m = 0; ar_m = 0; exp_dout = 0;
      exp_tv = 0; exp_ovf = 0;
      land_q.delete(); data_q.delete();
    end else begin
      if (land_q.size() > 0 && land_q[0] == cyc) begin
        if (exp_tv && !bus.tx_ready) exp_ovf = 1;
        exp_dout = data_q.pop_front();
        void'(land_q.pop_front());
        exp_tv = 1;
      end else if (exp_tv && bus.tx_ready) begin
        exp_tv = 0;
      end
      if (bus.rx_valid) begin
        mop = bus.din[9:8];
        pl  = bus.din[7:0];
        case (mop)
          2'd0: aw_m = pl;
          2'd1: begin
            mem_m[aw_m] = pl;
            if (AI) aw_m = 8'((int'(aw_m) + 1) % DEPTH);
          end
          2'd2: ar_m = pl;
          default: begin
            land_q.push_back(cyc + 1);
            data_q.push_back(mem_m[ar_m]);
            if (AI) ar_m = 8'((int'(ar_m) + 1) % DEPTH);
          end
        endcase
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic cmd(op_e op, logic [7:0] pl);
    bus.rx_valid = 1'b1;
    bus.din      = {op, pl};
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.din      = '0;
  endtask

  task automatic wait_tv(int n);
    int k = 0;
    while (!bus.tx_valid && k < n) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!bus.tx_valid) begin
      errors++;
      $display("FAIL wait_tv: got tx_valid 0 want 1 within %0d cycles", n);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.din      = '0;
    bus.tx_ready = 1'b1;
    idle(2);
    rst = 1'b0;

    chk("rst_tv", bus.tx_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_ovf", bus.ovf, 0);

    fork
      forever begin
        @(posedge clk);
        #1;
        chk("m_tv", bus.tx_valid, exp_tv);
        chk("m_ovf", bus.ovf, exp_ovf);
        if (exp_tv) chk("m_dout", bus.dout, exp_dout);
        if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.dout);
      end
    join_none

    // basic write then read, two-cycle latency, one-cycle tx pulse
    cmd(OP_WADDR, 8'h10);
    cmd(OP_WDATA, 8'hA5);
    cmd(OP_RADDR, 8'h10);
    cmd(OP_RDATA, 8'h00);
    chk("t1_tv_early", bus.tx_valid, 0);
    idle(1);
    chk("t1_tv", bus.tx_valid, 1);
    chk("t1_dout", bus.dout, 8'hA5);
    idle(1);
    chk("t1_tv_drop", bus.tx_valid, 0);
    chk("t1_cnt", got_q.size(), 1);
    chk("t1_got", got_q[0], 8'hA5);
    got_q.delete();

`ifdef SPI_RAM_AUTOINC_EN
    cmd(OP_WADDR, 8'hFE);
    cmd(OP_WDATA, 8'h11);
    cmd(OP_WDATA, 8'h22);
    cmd(OP_WDATA, 8'h33);
    cmd(OP_RADDR, 8'hFE);
    cmd(OP_RDATA, 8'h00);
    cmd(OP_RDATA, 8'h00);
    cmd(OP_RDATA, 8'h00);
    idle(3);
    chk("t2_cnt", got_q.size(), 3);
    chk("t2_w0", got_q[0], 8'h11);
    chk("t2_w1", got_q[1], 8'h22);
    chk("t2_w2", got_q[2], 8'h33);
`else
    cmd(OP_WADDR, 8'h03);
    cmd(OP_WDATA, 8'h01);
    cmd(OP_WDATA, 8'h02);
    cmd(OP_RADDR, 8'h03);
    cmd(OP_RDATA, 8'h00);
    cmd(OP_RDATA, 8'h00);
    idle(3);
    chk("t6_cnt", got_q.size(), 2);
    chk("t6_w0", got_q[0], 8'h02);
    chk("t6_w1", got_q[1], 8'h02);
`endif
    got_q.delete();

    // write immediately followed by read of the same word
    cmd(OP_WADDR, 8'h05);
    cmd(OP_RADDR, 8'h05);
    cmd(OP_WDATA, 8'h5A);
    cmd(OP_RDATA, 8'h00);
    wait_tv(4);
    chk("t4_dout", bus.dout, 8'h5A);
    idle(2);
    got_q.delete();

    // overrun while the slave is stalled
    cmd(OP_WADDR, 8'h20);
    cmd(OP_WDATA, 8'hC1);
    cmd(OP_WADDR, 8'h21);
    cmd(OP_WDATA, 8'hC2);
    cmd(OP_RADDR, 8'h20);
    bus.tx_ready = 1'b0;
    cmd(OP_RDATA, 8'h00);
    cmd(OP_RADDR, 8'h21);
    idle(1);
    cmd(OP_RDATA, 8'h00);
    chk("t3_tv1", bus.tx_valid, 1);
    chk("t3_dout1", bus.dout, 8'hC1);
    chk("t3_ovf0", bus.ovf, 0);
    idle(1);
    chk("t3_ovf1", bus.ovf, 1);
    chk("t3_dout2", bus.dout, 8'hC2);
    idle(2);
    chk("t3_hold", bus.tx_valid, 1);
    bus.tx_ready = 1'b1;
    idle(1);
    chk("t3_ack", bus.tx_valid, 0);
    chk("t3_sticky", bus.ovf, 1);
    got_q.delete();

    // reset while a read is in flight
    cmd(OP_WADDR, 8'h40);
    cmd(OP_WDATA, 8'h77);
    cmd(OP_RADDR, 8'h40);
    cmd(OP_RDATA, 8'h00);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_tv", bus.tx_valid, 0);
    chk("t5_ovf", bus.ovf, 0);
    chk("t5_dout", bus.dout, 0);
    idle(3);
    chk("t5_tv_late", bus.tx_valid, 0);
    cmd(OP_WDATA, 8'h99);
    cmd(OP_RDATA, 8'h00);
    wait_tv(4);
    chk("t5_addr0", bus.dout, 8'h99);
    idle(1);
    cmd(OP_RADDR, 8'h40);
    cmd(OP_RDATA, 8'h00);
    wait_tv(4);
    chk("t5_keep", bus.dout, 8'h77);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
